program_counter: RTL and testbench
==================================

# program_counter

Fetch-stage program counter for the 5-stage pipelined RV32I core. Holds the address of the instruction being fetched. Each cycle it does one of four things: advances by 4, holds for a pipeline stall, redirects to a branch target resolved in EX, or redirects to a flush target (trap or misprediction recovery). Its output drives instruction-memory addressing and the IF/ID pipeline register.

## Interface
Parameters:
- XLEN, 32, address/data width of the PC.
- RESET_VECTOR, 32'h0000_0000, value loaded into `pc` while reset is asserted.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_  input  1  reset, asynchronous and active-high. One clock; reset is asynchronous and active-high.
- stall  input  1  hazard unit request to hold the current PC.
- branch  input  1  taken-branch/jump redirect request from EX.
- flush  input  1  pipeline flush redirect request; highest priority.
- pc_branch  input  XLEN  branch/jump target, used when `branch`=1.
- pc_flush  input  XLEN  flush target, used when `flush`=1.
- pc  output  XLEN  registered current fetch address.
- pc_plus4  output  XLEN  combinational `pc + PC_STEP`, for link-address generation.
- redirect  output  1  registered; 1 for the single cycle after a flush or branch load.
- misaligned  output  1  registered; 1 for the single cycle after a redirect whose target had bits [1:0] ≠ 0.

## Operation
- Next-PC selection uses a fixed priority: flush > branch > stall > sequential.
  - flush=1: next = {pc_flush[XLEN-1:2], 2'b00}.
  - else branch=1: next = {pc_branch[XLEN-1:2], 2'b00}.
  - else stall=1: next = pc (hold).
  - else: next = pc + PC_STEP, modulo 2^XLEN.
- Redirects override stall. A branch or flush taken in a stalled cycle still loads its target.
- Targets are forced word-aligned by clearing bits [1:0]. `misaligned` reports that the original target bits [1:0] were nonzero. It is a flag only; the core's trap logic consumes it.
- Wrap-around: pc = 32'hFFFF_FFFC with no other request → next = 32'h0000_0000. No error is raised.
- `pc_plus4` is always pc + PC_STEP, independent of stall.
- `redirect` is set to (flush | branch) on each clock edge. It is cleared in every other cycle.
- `misaligned` is set on each clock edge to ((flush ? pc_flush[1:0] : pc_branch[1:0]) ≠ 0) & (flush | branch). It is cleared in every other cycle.

## Timing
- Reset: while rst_=1, pc = RESET_VECTOR, redirect = 0 and misaligned = 0. This takes effect immediately, without waiting for a clock edge.
- Reset release: the first rising edge after rst_ falls applies the normal selection. With no requests, pc becomes RESET_VECTOR+4.
- Reset asserted mid-operation, including during a stall or redirect, overrides everything asynchronously.
- Latency: control inputs are sampled at a rising edge, and the new `pc` is visible after that same edge. Redirect latency is therefore 1 cycle.
- Stall: pc stays constant for every cycle in which stall=1 is sampled. Incrementing resumes on the first edge with stall=0.
- Inputs are level-sensitive; there is no handshake. A request held for N cycles acts on N edges. For example, branch held for 2 edges reloads the same target twice.
- Simultaneous flush and branch: flush wins, and `pc_branch` is ignored.

## Test plan
- Reset: rst_=1 for 12 ns, then rst_=0 → pc=0 during reset. Then pc takes the values 4, 8, 12… on successive edges.
- Stall: stall=1 for 2 edges while pc=8 → pc stays 8. Then stall=0 → pc goes 12, 16.
- Branch: pc_branch=32'h40, branch=1 for 1 edge → pc=32'h40 and redirect=1 for one cycle. Then pc=32'h44, 32'h48.
- Flush priority: flush=1 with pc_flush=32'h100 and branch=1 with pc_branch=32'h40, both on the same edge, with stall=1 → pc=32'h100. The next edge, with no requests, gives 32'h104.
- Misaligned target and wrap: branch with pc_branch=32'h43 → pc=32'h40 and misaligned=1 for one cycle. Separately, flush to 32'hFFFF_FFFC followed by one idle edge → pc=0.
- Asynchronous reset mid-run: assert rst_ between clock edges while pc=32'h108 → pc=0 immediately, before the next edge.

Source files
------------

// File: rtl/program_counter.sv
// Fetch-stage program counter: sequential advance, stall hold, branch/flush redirect
// with word-alignment of targets and a one-cycle misaligned-target flag.
module program_counter #(
  parameter int unsigned       XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_VECTOR = '0,
  parameter int unsigned       PC_STEP      = 4
) (
  input  logic            clk,
  input  logic            rst_,
  input  logic            stall,
  input  logic            branch,
  input  logic            flush,
  input  logic [XLEN-1:0] pc_branch,
  input  logic [XLEN-1:0] pc_flush,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            redirect,
  output logic            misaligned
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            redirect_q, redirect_d;
  logic            misaligned_q, misaligned_d;
  logic [XLEN-1:0] target;
  logic            take_redirect;

  // Next-PC selection: flush > branch > stall > sequential
  always_comb begin
    pc_d          = pc_q;
    redirect_d    = 1'b0;
    misaligned_d  = 1'b0;
    take_redirect = flush | branch;
    target        = flush ? pc_flush : pc_branch;
    pc_plus4      = pc_q + XLEN'(PC_STEP);

    if (take_redirect) begin
      pc_d         = {target[XLEN-1:2], 2'b00};
      redirect_d   = 1'b1;
      misaligned_d = |target[1:0];
    end else if (!stall) begin
      pc_d = pc_plus4;
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      pc_q         <= RESET_VECTOR;
      redirect_q   <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      redirect_q   <= redirect_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign pc         = pc_q;
  assign redirect   = redirect_q;
  assign misaligned = misaligned_q;

endmodule

// File: tb/tb_program_counter.sv
// Bench for program_counter: directed scenarios plus randomized requests,
// all checked against a priority-rule reference model of the fetch PC.
module tb_program_counter;

  logic        clk = 1'b0;
  logic        rst_;
  logic        stall, branch, flush;
  logic [31:0] pc_branch, pc_flush;
  logic [31:0] pc, pc_plus4;
  logic        redirect, misaligned;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc;
  logic        m_redir, m_mis;

  program_counter dut (
    .clk       (clk),
    .rst_      (rst_),
    .stall     (stall),
    .branch    (branch),
    .flush     (flush),
    .pc_branch (pc_branch),
    .pc_flush  (pc_flush),
    .pc        (pc),
    .pc_plus4  (pc_plus4),
    .redirect  (redirect),
    .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge, updating the reference from the request rules,
  // and return at the following falling edge for checking/driving.
  task automatic step();
    logic [31:0] tgt;
    @(posedge clk);
    tgt     = flush ? pc_flush : pc_branch;
    m_redir = flush | branch;
    m_mis   = (flush | branch) && ((tgt % 32'd4) != 32'd0);
    if (flush | branch) m_pc = tgt - (tgt % 32'd4);
    else if (!stall)    m_pc = m_pc + 32'd4;
    @(negedge clk);
  endtask

  task automatic idle();
    stall = 0; branch = 0; flush = 0;
  endtask

  task automatic test_reset();
    rst_ = 1; idle(); pc_branch = 0; pc_flush = 0;
    #3;
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc_async got=%h want=%h", pc, 32'h0); end
    total++; if (redirect !== 1'b0 || misaligned !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b want=00", redirect, misaligned); end
    #5;
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL reset_pc_held got=%h want=%h", pc, 32'h0); end
    #4; rst_ = 0;
    m_pc = 0; m_redir = 0; m_mis = 0;
    step();
    total++; if (pc !== 32'h4) begin bad++; $display("FAIL reset_release_1 got=%h want=%h", pc, 32'h4); end
    step();
    total++; if (pc !== 32'h8) begin bad++; $display("FAIL reset_release_2 got=%h want=%h", pc, 32'h8); end
  endtask

  task automatic test_stall();
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (pc !== 32'h8) begin bad++; $display("FAIL stall_hold_%0d got=%h want=%h", i, pc, 32'h8); end
      total++; if (pc_plus4 !== 32'hC) begin bad++; $display("FAIL stall_plus4_%0d got=%h want=%h", i, pc_plus4, 32'hC); end
    end
    stall = 0;
    step();
    total++; if (pc !== 32'hC) begin bad++; $display("FAIL stall_resume_1 got=%h want=%h", pc, 32'hC); end
    step();
    total++; if (pc !== 32'h10) begin bad++; $display("FAIL stall_resume_2 got=%h want=%h", pc, 32'h10); end
  endtask

  task automatic test_branch();
    pc_branch = 32'h40; branch = 1;
    step();
    total++; if (pc !== 32'h40) begin bad++; $display("FAIL branch_pc got=%h want=%h", pc, 32'h40); end
    total++; if (redirect !== 1'b1) begin bad++; $display("FAIL branch_redirect got=%b want=1", redirect); end
    total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL branch_aligned got=%b want=0", misaligned); end
    branch = 0;
    step();
    total++; if (pc !== 32'h44) begin bad++; $display("FAIL branch_next1 got=%h want=%h", pc, 32'h44); end
    total++; if (redirect !== 1'b0) begin bad++; $display("FAIL branch_redirect_clear got=%b want=0", redirect); end
    step();
    total++; if (pc !== 32'h48) begin bad++; $display("FAIL branch_next2 got=%h want=%h", pc, 32'h48); end
  endtask

  task automatic test_flush_priority();
    flush = 1; pc_flush = 32'h100; branch = 1; pc_branch = 32'h40; stall = 1;
    step();
    total++; if (pc !== 32'h100) begin bad++; $display("FAIL flush_prio_pc got=%h want=%h", pc, 32'h100); end
    total++; if (redirect !== 1'b1) begin bad++; $display("FAIL flush_prio_redirect got=%b want=1", redirect); end
    idle();
    step();
    total++; if (pc !== 32'h104) begin bad++; $display("FAIL flush_prio_next got=%h want=%h", pc, 32'h104); end
  endtask

  task automatic test_misaligned_wrap();
    pc_branch = 32'h43; branch = 1;
    step();
    total++; if (pc !== 32'h40) begin bad++; $display("FAIL misaligned_pc got=%h want=%h", pc, 32'h40); end
    total++; if (misaligned !== 1'b1) begin bad++; $display("FAIL misaligned_flag got=%b want=1", misaligned); end
    branch = 0;
    step();
    total++; if (misaligned !== 1'b0) begin bad++; $display("FAIL misaligned_clear got=%b want=0", misaligned); end
    pc_flush = 32'hFFFF_FFFC; flush = 1;
    step();
    total++; if (pc !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_load got=%h want=%h", pc, 32'hFFFF_FFFC); end
    total++; if (pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_plus4 got=%h want=%h", pc_plus4, 32'h0); end
    flush = 0;
    step();
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_pc got=%h want=%h", pc, 32'h0); end
  endtask

  task automatic test_async_reset();
    pc_flush = 32'h108; flush = 1; stall = 1;
    step();
    total++; if (pc !== 32'h108) begin bad++; $display("FAIL areset_setup got=%h want=%h", pc, 32'h108); end
    #2 rst_ = 1;
    #1;
    total++; if (pc !== 32'h0) begin bad++; $display("FAIL areset_pc got=%h want=%h", pc, 32'h0); end
    total++; if (redirect !== 1'b0) begin bad++; $display("FAIL areset_redirect got=%b want=0", redirect); end
    #1 rst_ = 0; idle();
    m_pc = 0; m_redir = 0; m_mis = 0;
    step();
    total++; if (pc !== 32'h4) begin bad++; $display("FAIL areset_release got=%h want=%h", pc, 32'h4); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      stall     = ($urandom_range(0, 3) == 0);
      branch    = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 7) == 0);
      pc_branch = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
      pc_flush  = $urandom;
      if ($urandom_range(0, 39) == 0) begin
        #2 rst_ = 1;
        #1;
        total++; if (pc !== 32'h0 || redirect !== 1'b0 || misaligned !== 1'b0) begin
          bad++; $display("FAIL rand_reset_%0d got=%h/%b/%b want=0/0/0", i, pc, redirect, misaligned);
        end
        #1 rst_ = 0;
        m_pc = 0; m_redir = 0; m_mis = 0;
      end
      step();
      total++; if (pc !== m_pc) begin bad++; $display("FAIL rand_pc_%0d got=%h want=%h", i, pc, m_pc); end
      total++; if (redirect !== m_redir) begin bad++; $display("FAIL rand_redirect_%0d got=%b want=%b", i, redirect, m_redir); end
      total++; if (misaligned !== m_mis) begin bad++; $display("FAIL rand_misaligned_%0d got=%b want=%b", i, misaligned, m_mis); end
      total++; if (pc_plus4 !== m_pc + 32'd4) begin bad++; $display("FAIL rand_plus4_%0d got=%h want=%h", i, pc_plus4, m_pc + 32'd4); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_stall();
    idle(); pc_branch = 0; pc_flush = 0;
    test_branch();
    test_flush_priority();
    test_misaligned_wrap();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
